arp_ctrl: RTL and testbench
===========================

Name: arp_ctrl

Overview:
- Control stage directly upstream of the ARP MAC/PHY block. It consumes that block's receive outputs (arp_rx_done, arp_rx_type, src_mac, src_ip) and drives its transmit inputs (arp_tx_en, arp_tx_type, des_mac, des_ip), handshaking on tx_done.
- Answers incoming ARP requests automatically and resolves IP addresses on demand, with timeout and retry.
- Holds a single-entry ARP cache that the UDP/IP transmit path uses as its destination MAC.

Parameters:
- TIMEOUT_CYC, 125000000, cycles to wait for an ARP reply after a request frame finishes (1 s at 125 MHz).
- MAX_RETRY, 3, request retransmissions allowed after the first attempt before failing.
- CNT_W, 32, width of the timeout and aging counters.
- AGE_CYC, 32'hFFFF_FFFF, cache lifetime in cycles; used only when ARP_AGING_EN is defined.

Ports:
- clk  in  1  single clock, the GMII clock shared with the ARP block.
- rst_n  in  1  asynchronous active-low reset.
- arp_rx_done  in  1  one-cycle pulse: an ARP frame addressed to the board was received.
- arp_rx_type  in  1  0 = request, 1 = reply; valid with arp_rx_done.
- src_mac  in  48  sender MAC of the received frame.
- src_ip  in  32  sender IP of the received frame.
- arp_tx_en  out  1  one-cycle pulse that starts an ARP transmit.
- arp_tx_type  out  1  0 = request, 1 = reply.
- des_mac  out  48  destination MAC for the transmit.
- des_ip  out  32  destination IP for the transmit.
- tx_done  in  1  one-cycle pulse: the transmit frame has completed.
- resolve_req  in  1  pulse: resolve resolve_ip.
- resolve_ip  in  32  IP to resolve; sampled with resolve_req.
- resolve_busy  out  1  high while a resolve is in progress.
- resolve_done  out  1  one-cycle pulse: the cache now holds resolve_ip.
- resolve_fail  out  1  one-cycle pulse: retries exhausted.
- cache_valid  out  1  the cache entry is valid.
- cache_mac  out  48  cached MAC.
- cache_ip  out  32  cached IP.

Behaviour:
- Reset values: all outputs 0; des_mac and des_ip 0; state IDLE; reply-pending flag clear; counters 0. Reset asserted mid-frame aborts immediately. Any tx_done arriving after release is ignored in IDLE.
- Cache learning:
  - Every arp_rx_done (request or reply) loads cache_mac/cache_ip from src_mac/src_ip and sets cache_valid on the next cycle.
  - A new frame overwrites the entry, newest wins.
- Reply pending:
  - arp_rx_done with type 0 sets reply_pend and latches the peer MAC/IP in a reply register.
  - A second request before service overwrites the latched peer (one deep).
- State machine (IDLE, SEND_REPLY, SEND_REQ, WAIT_TX, WAIT_RESP):
  - IDLE: reply_pend has priority and goes to SEND_REPLY. Otherwise, on resolve_req:
    - cache hit (cache_valid and cache_ip == resolve_ip): resolve_done the next cycle, no transmit, stay IDLE.
    - miss: latch target IP, clear retry count, raise resolve_busy, go to SEND_REQ.
  - SEND_REPLY: one-cycle arp_tx_en, type 1, des_mac/des_ip from the reply register. Clear reply_pend, record return state, go to WAIT_TX.
  - SEND_REQ: one-cycle arp_tx_en, type 0, des_mac = 48'hFFFF_FFFF_FFFF, des_ip = target. Go to WAIT_TX.
  - WAIT_TX: hold all des_* and arp_tx_type stable until tx_done.
    - After a reply: return to the recorded state (IDLE or WAIT_RESP).
    - After a request: clear the timer and go to WAIT_RESP.
  - WAIT_RESP: timer increments every cycle.
    - arp_rx_done, type 1, src_ip == target: resolve_done pulse (same cycle the cache updates), drop busy, go to IDLE.
    - reply_pend set: go to SEND_REPLY with return state WAIT_RESP. The timer keeps running through the reply and saturates at TIMEOUT_CYC-1.
    - Timer reaches TIMEOUT_CYC-1:
      - retry < MAX_RETRY: retry+1, go to SEND_REQ.
      - else: resolve_fail pulse, drop busy, go to IDLE.
- resolve_req is ignored while resolve_busy is high.
- Latency:
  - Request received to arp_tx_en: 2 cycles in IDLE.
  - Cache hit to resolve_done: 1 cycle.
- A matching reply arriving in the same cycle as the timeout wins (done, not retry).
- Exactly 1 + MAX_RETRY requests are sent before resolve_fail.

Optional Feature:
- Macro ARP_AGING_EN.
- Defined:
  - An age counter clears on every cache load and increments otherwise.
  - At AGE_CYC-1, cache_valid clears.
  - A resolve_req on a stale entry is treated as a miss.
- Undefined: no age counter; the entry stays valid until overwritten or reset.

Decomposition:
- Shared package arp_pkg:
  - ARP_TYPE_REQ = 1'b0, ARP_TYPE_REP = 1'b1.
  - BCAST_MAC = 48'hFFFF_FFFF_FFFF.
  - State encoding constants.
- One sub-module, arp_cache_entry: learning register, cache hit compare, and the aging counter under the macro.
- FSM and timers stay in arp_ctrl.

Test Plan:
- Request from 192.168.1.11 / MAC 00:11:22:33:44:55 in IDLE -> arp_tx_en 2 cycles later, type 1, des_ip C0A8010B. cache_valid=1, cache_ip C0A8010B.
- resolve_req C0A8010B with the cache holding it -> resolve_done after 1 cycle, no arp_tx_en.
- resolve_req C0A8010C on a miss -> request to FF..FF. Inject reply src_ip C0A8010C, MAC AA..AA -> resolve_done; cache_mac AABBCCDDEEFF.
- TIMEOUT_CYC=100, MAX_RETRY=2, no reply -> 3 request pulses, each 100 cycles after tx_done, then one resolve_fail; busy drops.
- Peer request arrives during WAIT_RESP -> reply sent, FSM returns to WAIT_RESP. Timeout still fires at 100 cycles from the original tx_done.
- ARP_AGING_EN, AGE_CYC=50 -> cache_valid clears 50 cycles after load. rst_n pulsed mid-WAIT_TX -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/arp_pkg.sv
// ---------------------------------------------------------------------------
// arp_pkg: shared definitions for the ARP control slice.
//   - ARP frame type codes seen on arp_rx_type / arp_tx_type
//   - broadcast MAC used as the destination of ARP requests
//   - MAC/IP typedefs and the controller state encoding
//   - cache_hit(): single-entry cache lookup compare
// ---------------------------------------------------------------------------
package arp_pkg;

   localparam logic        ARP_TYPE_REQ = 1'b0;
   localparam logic        ARP_TYPE_REP = 1'b1;
   localparam logic [47:0] BCAST_MAC    = 48'hFFFF_FFFF_FFFF;

   typedef logic [47:0] mac_t;
   typedef logic [31:0] ip_t;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_SEND_REPLY = 3'd1,
      ST_SEND_REQ   = 3'd2,
      ST_WAIT_TX    = 3'd3,
      ST_WAIT_RESP  = 3'd4
   } arp_state_t;

   function automatic logic cache_hit(input logic valid, input ip_t entry_ip, input ip_t ip);
      return valid && (entry_ip == ip);
   endfunction

endpackage

// File: rtl/arp_if.sv
// ---------------------------------------------------------------------------
// arp_if: signals between the ARP controller and the ARP MAC/PHY block.
//   receive side : arp_rx_done, arp_rx_type, src_mac, src_ip
//   transmit side: arp_tx_en, arp_tx_type, des_mac, des_ip, tx_done
// modport master = controller (arp_ctrl), modport slave = ARP MAC/PHY block.
// ---------------------------------------------------------------------------
interface arp_if;
   import arp_pkg::*;

   logic arp_rx_done;
   logic arp_rx_type;
   mac_t src_mac;
   ip_t  src_ip;
   logic arp_tx_en;
   logic arp_tx_type;
   mac_t des_mac;
   ip_t  des_ip;
   logic tx_done;

   modport master (
      input  arp_rx_done, arp_rx_type, src_mac, src_ip, tx_done,
      output arp_tx_en, arp_tx_type, des_mac, des_ip
   );

   modport slave (
      output arp_rx_done, arp_rx_type, src_mac, src_ip, tx_done,
      input  arp_tx_en, arp_tx_type, des_mac, des_ip
   );

endinterface

// File: rtl/arp_cache_entry.sv
// ---------------------------------------------------------------------------
// arp_cache_entry: single-entry ARP cache.
//   Every load (any received ARP frame) overwrites the entry; newest wins.
//   hit is a combinational compare of cmp_ip against the valid entry.
// Build option: ARP_AGING_EN -- when defined, an age counter clears on each
//   load and cache_valid drops once it reaches AGE_CYC-1, so lookups on a
//   stale entry miss. When undefined the entry lives until overwritten/reset.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   load                  capture load_mac/load_ip
//   load_mac, load_ip     sender addresses of the received frame
//   cmp_ip                address being looked up
//   cache_valid/mac/ip    current entry
//   hit                   cmp_ip matches the valid entry
// ---------------------------------------------------------------------------
module arp_cache_entry
   import arp_pkg::*;
#(
   parameter int unsigned CNT_W   = 32,
   parameter logic [31:0] AGE_CYC = 32'hFFFF_FFFF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  mac_t load_mac,
   input  ip_t  load_ip,
   input  ip_t  cmp_ip,
   output logic cache_valid,
   output mac_t cache_mac,
   output ip_t  cache_ip,
   output logic hit
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cache_mac <= '0;
         cache_ip  <= '0;
      end else if (load) begin
         cache_mac <= load_mac;
         cache_ip  <= load_ip;
      end
   end

`ifdef ARP_AGING_EN
   localparam logic [CNT_W-1:0] AGE_LAST = CNT_W'(AGE_CYC - 32'd1);

   logic [CNT_W-1:0] age_q;

   // Age freezes once the entry has expired; only a new load restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         age_q <= '0;
      end else if (load) begin
         age_q <= '0;
      end else if (cache_valid && (age_q != AGE_LAST)) begin
         age_q <= age_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cache_valid <= 1'b0;
      end else if (load) begin
         cache_valid <= 1'b1;
      end else if (cache_valid && (age_q == AGE_LAST)) begin
         cache_valid <= 1'b0;
      end
   end
`else
   logic unused_age_cfg;
   assign unused_age_cfg = (^AGE_CYC) ^ (CNT_W == 0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cache_valid <= 1'b0;
      end else if (load) begin
         cache_valid <= 1'b1;
      end
   end
`endif

   assign hit = cache_hit(cache_valid, cache_ip, cmp_ip);

endmodule

// File: rtl/arp_ctrl.sv
// ---------------------------------------------------------------------------
// arp_ctrl: ARP control stage in front of the ARP MAC/PHY block.
//   Answers incoming ARP requests, resolves IP addresses on demand with
//   timeout/retry, and keeps a single-entry ARP cache for the IP TX path.
// Build option: ARP_AGING_EN (cache aging, see arp_cache_entry).
// Ports:
//   clk, rst_n                  GMII clock, async active-low reset
//   arp (arp_if.master)         rx results in, tx request/handshake out
//   resolve_req, resolve_ip     pulse to resolve an IP address
//   resolve_busy                resolve in progress (new requests ignored)
//   resolve_done, resolve_fail  one-cycle completion pulses
//   cache_valid/mac/ip          cache entry for the IP transmit path
//
// state        | meaning
// -------------+------------------------------------------------------------
// IDLE         | no frame in flight; serve pending reply, else accept resolve
// SEND_REPLY   | arp_tx_en pulse for a reply to the latched peer
// SEND_REQ     | arp_tx_en pulse for a broadcast request for the target IP
// WAIT_TX      | frame on the wire, des_* held until tx_done
// WAIT_RESP    | waiting for the target's reply, timer running
// ---------------------------------------------------------------------------
module arp_ctrl
   import arp_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 125000000,
   parameter int unsigned MAX_RETRY   = 3,
   parameter int unsigned CNT_W       = 32,
   parameter logic [31:0] AGE_CYC     = 32'hFFFF_FFFF
) (
   input  logic  clk,
   input  logic  rst_n,
   arp_if.master arp,
   input  logic  resolve_req,
   input  ip_t   resolve_ip,
   output logic  resolve_busy,
   output logic  resolve_done,
   output logic  resolve_fail,
   output logic  cache_valid,
   output mac_t  cache_mac,
   output ip_t   cache_ip
);

   localparam int unsigned      RTY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

   arp_state_t       state_q, state_d;
   logic             reply_pend_q;
   mac_t             rep_mac_q;
   ip_t              rep_ip_q;
   logic             ret_wait_q;
   ip_t              target_ip_q;
   logic [RTY_W-1:0] retry_q;
   logic [CNT_W-1:0] timer_q;
   logic             busy_q, done_q, fail_q;
   logic             type_q;
   mac_t             des_mac_q;
   ip_t              des_ip_q;

   logic             hit;
   logic             rx_req, rx_match, timed_out, can_retry;
   logic             idle_free, start_hit, start_miss, timer_run;
   logic             tx_en, tx_type;
   mac_t             tx_mac;
   ip_t              tx_ip;

   arp_cache_entry #(
      .CNT_W   (CNT_W),
      .AGE_CYC (AGE_CYC)
   ) u_cache (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (arp.arp_rx_done),
      .load_mac    (arp.src_mac),
      .load_ip     (arp.src_ip),
      .cmp_ip      (resolve_ip),
      .cache_valid (cache_valid),
      .cache_mac   (cache_mac),
      .cache_ip    (cache_ip),
      .hit         (hit)
   );

   assign rx_req     = arp.arp_rx_done && (arp.arp_rx_type == ARP_TYPE_REQ);
   assign rx_match   = arp.arp_rx_done && (arp.arp_rx_type == ARP_TYPE_REP) &&
                       (arp.src_ip == target_ip_q);
   assign timed_out  = (timer_q == TMO_LAST);
   assign can_retry  = (retry_q < RTY_W'(MAX_RETRY));
   assign idle_free  = (state_q == ST_IDLE) && !reply_pend_q && !busy_q;
   assign start_hit  = idle_free && resolve_req && hit;
   assign start_miss = idle_free && resolve_req && !hit;

   // The response timeout keeps counting while a peer reply is squeezed in
   // during WAIT_RESP, so the detour never stretches the resolve window.
   assign timer_run  = (state_q == ST_WAIT_RESP) ||
                       (ret_wait_q && ((state_q == ST_SEND_REPLY) ||
                                       ((state_q == ST_WAIT_TX) && (type_q == ARP_TYPE_REP))));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (reply_pend_q) begin
               state_d = ST_SEND_REPLY;
            end else if (start_miss) begin
               state_d = ST_SEND_REQ;
            end
         end
         ST_SEND_REPLY, ST_SEND_REQ: begin
            state_d = ST_WAIT_TX;
         end
         ST_WAIT_TX: begin
            if (arp.tx_done) begin
               state_d = ((type_q == ARP_TYPE_REP) && !ret_wait_q) ? ST_IDLE : ST_WAIT_RESP;
            end
         end
         ST_WAIT_RESP: begin
            // A matching reply beats a timeout landing in the same cycle.
            if (rx_match) begin
               state_d = ST_IDLE;
            end else if (reply_pend_q) begin
               state_d = ST_SEND_REPLY;
            end else if (timed_out) begin
               state_d = can_retry ? ST_SEND_REQ : ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // des_*/type are driven straight from their sources in the SEND states so
   // they line up with arp_tx_en, then held from the registers in WAIT_TX.
   always_comb begin
      tx_en   = 1'b0;
      tx_type = type_q;
      tx_mac  = des_mac_q;
      tx_ip   = des_ip_q;
      case (state_q)
         ST_SEND_REPLY: begin
            tx_en   = 1'b1;
            tx_type = ARP_TYPE_REP;
            tx_mac  = rep_mac_q;
            tx_ip   = rep_ip_q;
         end
         ST_SEND_REQ: begin
            tx_en   = 1'b1;
            tx_type = ARP_TYPE_REQ;
            tx_mac  = BCAST_MAC;
            tx_ip   = target_ip_q;
         end
         default: begin
            tx_en = 1'b0;
         end
      endcase
   end

   assign arp.arp_tx_en   = tx_en;
   assign arp.arp_tx_type = tx_type;
   assign arp.des_mac     = tx_mac;
   assign arp.des_ip      = tx_ip;
   assign resolve_busy    = busy_q;
   assign resolve_done    = done_q;
   assign resolve_fail    = fail_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         type_q    <= ARP_TYPE_REQ;
         des_mac_q <= '0;
         des_ip_q  <= '0;
      end else begin
         type_q    <= tx_type;
         des_mac_q <= tx_mac;
         des_ip_q  <= tx_ip;
      end
   end

   // One-deep reply queue: a newer request replaces an unserved one. A request
   // arriving in the SEND_REPLY cycle keeps the flag set for the next reply.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reply_pend_q <= 1'b0;
         rep_mac_q    <= '0;
         rep_ip_q     <= '0;
      end else if (rx_req) begin
         reply_pend_q <= 1'b1;
         rep_mac_q    <= arp.src_mac;
         rep_ip_q     <= arp.src_ip;
      end else if (state_q == ST_SEND_REPLY) begin
         reply_pend_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ret_wait_q <= 1'b0;
      end else if ((state_d == ST_SEND_REPLY) && (state_q != ST_SEND_REPLY)) begin
         ret_wait_q <= (state_q == ST_WAIT_RESP);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         target_ip_q <= '0;
         retry_q     <= '0;
         busy_q      <= 1'b0;
      end else if (start_miss) begin
         target_ip_q <= resolve_ip;
         retry_q     <= '0;
         busy_q      <= 1'b1;
      end else if (state_q == ST_WAIT_RESP) begin
         if (state_d == ST_SEND_REQ) begin
            retry_q <= retry_q + RTY_W'(1);
         end else if (state_d == ST_IDLE) begin
            busy_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q <= '0;
      end else if ((state_q == ST_WAIT_TX) && arp.tx_done && (type_q == ARP_TYPE_REQ)) begin
         timer_q <= '0;
      end else if (timer_run && !timed_out) begin
         timer_q <= timer_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q <= 1'b0;
         fail_q <= 1'b0;
      end else begin
         done_q <= start_hit || ((state_q == ST_WAIT_RESP) && rx_match);
         fail_q <= (state_q == ST_WAIT_RESP) && !rx_match && !reply_pend_q &&
                   timed_out && !can_retry;
      end
   end

endmodule

// File: tb/tb_arp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_arp_ctrl: scoreboard bench for arp_ctrl (TIMEOUT_CYC=100, MAX_RETRY=2,
// AGE_CYC=50). Stimulus pushes expected tx/done/fail events with the cycle
// they must appear in; a monitor pops and compares each event the DUT shows.
// A small PHY model answers every arp_tx_en with tx_done TXD cycles later.
// ---------------------------------------------------------------------------
module tb_arp_ctrl;
   import arp_pkg::*;

   localparam int TXD    = 4;
   localparam int EV_TX   = 0;
   localparam int EV_DONE = 1;
   localparam int EV_FAIL = 2;

   typedef struct {
      int          kind;
      logic        typ;
      logic [47:0] mac;
      logic [31:0] ip;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        resolve_req = 1'b0;
   logic [31:0] resolve_ip = 32'h0;
   logic        resolve_busy, resolve_done, resolve_fail, cache_valid;
   logic [47:0] cache_mac;
   logic [31:0] cache_ip;

   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];

   arp_if bus();

   arp_ctrl #(
      .TIMEOUT_CYC (100),
      .MAX_RETRY   (2),
      .CNT_W       (32),
      .AGE_CYC     (32'd50)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .arp          (bus),
      .resolve_req  (resolve_req),
      .resolve_ip   (resolve_ip),
      .resolve_busy (resolve_busy),
      .resolve_done (resolve_done),
      .resolve_fail (resolve_fail),
      .cache_valid  (cache_valid),
      .cache_mac    (cache_mac),
      .cache_ip     (cache_ip)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
      end
   endtask

   function automatic void push(input int kind, input logic typ, input logic [47:0] mac,
                                input logic [31:0] ip, input int at);
      exp_t e;
      e.kind = kind; e.typ = typ; e.mac = mac; e.ip = ip; e.cyc = at;
      sb.push_back(e);
   endfunction

   task automatic score(input int kind, input logic typ, input logic [47:0] mac, input logic [31:0] ip);
      exp_t e;
      n_vec++;
      if (sb.size() == 0) begin
         n_err++;
         $display("FAIL unexpected_event: got kind=%0d type=%0b mac=%h ip=%h cyc=%0d, want none",
                  kind, typ, mac, ip, cyc);
      end else begin
         e = sb.pop_front();
         if (e.kind != kind || e.typ !== typ || e.mac !== mac || e.ip !== ip || e.cyc != cyc) begin
            n_err++;
            $display("FAIL event: got kind=%0d type=%0b mac=%h ip=%h cyc=%0d, want kind=%0d type=%0b mac=%h ip=%h cyc=%0d",
                     kind, typ, mac, ip, cyc, e.kind, e.typ, e.mac, e.ip, e.cyc);
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.arp_tx_en) score(EV_TX, bus.arp_tx_type, bus.des_mac, bus.des_ip);
         if (resolve_done)  score(EV_DONE, 1'b0, cache_mac, cache_ip);
         if (resolve_fail)  score(EV_FAIL, 1'b0, 48'h0, 32'h0);
      end
   end

   // ARP MAC/PHY model: frame completes TXD cycles after arp_tx_en.
   initial begin : phy_model
      bus.tx_done = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.arp_tx_en) begin
            repeat (TXD) @(posedge clk);
            #1 bus.tx_done = 1'b1;
            @(posedge clk);
            #1 bus.tx_done = 1'b0;
         end
      end
   end

   task automatic at_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rx_frame(input int n, input logic typ, input logic [47:0] mac, input logic [31:0] ip);
      at_cyc(n);
      bus.arp_rx_done = 1'b1;
      bus.arp_rx_type = typ;
      bus.src_mac     = mac;
      bus.src_ip      = ip;
      @(posedge clk);
      #1 bus.arp_rx_done = 1'b0;
   endtask

   task automatic resolve(input int n, input logic [31:0] ip);
      at_cyc(n);
      resolve_req = 1'b1;
      resolve_ip  = ip;
      @(posedge clk);
      #1 resolve_req = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_tx_en"},   {63'h0, bus.arp_tx_en},   64'h0);
      chk({tag, "_tx_type"}, {63'h0, bus.arp_tx_type}, 64'h0);
      chk({tag, "_des_mac"}, {16'h0, bus.des_mac},     64'h0);
      chk({tag, "_des_ip"},  {32'h0, bus.des_ip},      64'h0);
      chk({tag, "_busy"},    {63'h0, resolve_busy},    64'h0);
      chk({tag, "_valid"},   {63'h0, cache_valid},     64'h0);
      chk({tag, "_cmac"},    {16'h0, cache_mac},       64'h0);
      chk({tag, "_cip"},     {32'h0, cache_ip},        64'h0);
   endtask

   initial begin : watchdog
      #50000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      bus.arp_rx_done = 1'b0;
      bus.arp_rx_type = 1'b0;
      bus.src_mac     = 48'h0;
      bus.src_ip      = 32'h0;

      at_cyc(2);
      chk_all_zero("reset");
      chk("reset_done", {62'h0, resolve_done, resolve_fail}, 64'h0);
      rst_n = 1'b1;

      // Peer request in IDLE: reply two cycles later, cache learns the peer.
      push(EV_TX, ARP_TYPE_REP, 48'h0011_2233_4455, 32'hC0A8_010B, 12);
      rx_frame(10, ARP_TYPE_REQ, 48'h0011_2233_4455, 32'hC0A8_010B);
      chk("learn_valid", {63'h0, cache_valid}, 64'h1);
      chk("learn_ip",    {32'h0, cache_ip},    64'hC0A8_010B);
      chk("learn_mac",   {16'h0, cache_mac},   64'h0011_2233_4455);

      // Cache hit: done one cycle later, nothing transmitted.
      push(EV_DONE, 1'b0, 48'h0011_2233_4455, 32'hC0A8_010B, 21);
      resolve(20, 32'hC0A8_010B);

      // Entry loaded at edge 11: valid for 50 cycles when aging is built in.
      at_cyc(60);
      chk("age_valid_60", {63'h0, cache_valid}, 64'h1);
      at_cyc(61);
`ifdef ARP_AGING_EN
      chk("age_valid_61", {63'h0, cache_valid}, 64'h0);
      push(EV_TX, ARP_TYPE_REQ, BCAST_MAC, 32'hC0A8_010B, 66);
      push(EV_DONE, 1'b0, 48'h0011_2233_4455, 32'hC0A8_010B, 76);
`else
      chk("age_valid_61", {63'h0, cache_valid}, 64'h1);
      push(EV_DONE, 1'b0, 48'h0011_2233_4455, 32'hC0A8_010B, 66);
`endif
      resolve(65, 32'hC0A8_010B);
      rx_frame(75, ARP_TYPE_REP, 48'h0011_2233_4455, 32'hC0A8_010B);

      // Miss: broadcast request, a non-matching reply is ignored, then match.
      push(EV_TX, ARP_TYPE_REQ, BCAST_MAC, 32'hC0A8_010C, 91);
      push(EV_DONE, 1'b0, 48'hAABB_CCDD_EEFF, 32'hC0A8_010C, 101);
      resolve(90, 32'hC0A8_010C);
      chk("miss_busy", {63'h0, resolve_busy}, 64'h1);
      rx_frame(98, ARP_TYPE_REP, 48'h1122_3344_5566, 32'hC0A8_0199);
      rx_frame(100, ARP_TYPE_REP, 48'hAABB_CCDD_EEFF, 32'hC0A8_010C);
      chk("miss_busy_drop", {63'h0, resolve_busy}, 64'h0);
      chk("miss_cache_mac", {16'h0, cache_mac},    64'hAABB_CCDD_EEFF);

      // No reply: 1 + MAX_RETRY requests, each TIMEOUT_CYC WAIT_RESP cycles
      // after the previous tx_done (TXD + 101 cycles apart), then one fail.
      push(EV_TX, ARP_TYPE_REQ, BCAST_MAC, 32'hC0A8_0120, 111);
      push(EV_TX, ARP_TYPE_REQ, BCAST_MAC, 32'hC0A8_0120, 216);
      push(EV_TX, ARP_TYPE_REQ, BCAST_MAC, 32'hC0A8_0120, 321);
      push(EV_FAIL, 1'b0, 48'h0, 32'h0, 426);
      resolve(110, 32'hC0A8_0120);
      at_cyc(425);
      chk("fail_busy_before", {63'h0, resolve_busy}, 64'h1);
      at_cyc(426);
      chk("fail_busy_after", {63'h0, resolve_busy}, 64'h0);

      // Peer request during WAIT_RESP: reply detour, timeout unaffected, then
      // a matching reply in the exact timeout cycle wins over the retry.
      push(EV_TX, ARP_TYPE_REQ, BCAST_MAC, 32'hC0A8_0130, 441);
      push(EV_TX, ARP_TYPE_REP, 48'h0A0B_0C0D_0E0F, 32'hC0A8_0140, 462);
      push(EV_TX, ARP_TYPE_REQ, BCAST_MAC, 32'hC0A8_0130, 546);
      push(EV_DONE, 1'b0, 48'h5A5A_5A5A_5A5A, 32'hC0A8_0130, 651);
      resolve(440, 32'hC0A8_0130);
      rx_frame(460, ARP_TYPE_REQ, 48'h0A0B_0C0D_0E0F, 32'hC0A8_0140);
      at_cyc(500);
      chk("detour_busy", {63'h0, resolve_busy}, 64'h1);
      rx_frame(650, ARP_TYPE_REP, 48'h5A5A_5A5A_5A5A, 32'hC0A8_0130);
      chk("tie_busy_drop", {63'h0, resolve_busy}, 64'h0);

      // Reset in WAIT_TX clears everything at once; late tx_done is ignored.
      push(EV_TX, ARP_TYPE_REP, 48'h1020_3040_5060, 32'hC0A8_0150, 672);
      rx_frame(670, ARP_TYPE_REQ, 48'h1020_3040_5060, 32'hC0A8_0150);
      at_cyc(674);
      chk("hold_type",    {63'h0, bus.arp_tx_type}, 64'h1);
      chk("hold_des_mac", {16'h0, bus.des_mac},     64'h1020_3040_5060);
      chk("hold_des_ip",  {32'h0, bus.des_ip},      64'hC0A8_0150);
      rst_n = 1'b0;
      #2;
      chk_all_zero("async_rst");
      at_cyc(675);
      rst_n = 1'b1;
      at_cyc(680);
      chk_all_zero("post_rst");

      at_cyc(690);
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_vec++;
         n_err++;
         $display("FAIL missing_event: got none, want kind=%0d type=%0b mac=%h ip=%h cyc=%0d",
                  e.kind, e.typ, e.mac, e.ip, e.cyc);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
